// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: bus/pipeline types, FSM state encodings and reset PC for the fetch stage
package fetch_ctrl_pkg;
  typedef logic [63:0] word_t;
  typedef struct packed {
    logic  valid;
    word_t addr;
  } ibus_req_t;
  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
  typedef struct packed {
    word_t       pc;
    logic [31:0] raw_instr;
  } instr_t;
  typedef struct packed {
    instr_t instr;
  } fetch_data_t;
  typedef logic [1:0] fetch_ctrl_state_t;
  localparam fetch_ctrl_state_t FC_IDLE    = 2'd0;
  localparam fetch_ctrl_state_t FC_REQ     = 2'd1;
  localparam fetch_ctrl_state_t FC_DISCARD = 2'd2;
  localparam word_t PCINIT = 64'h8000_0000;
endpackage

// File: rtl/fetch_ctrl_perf.sv
// fetch_ctrl_perf: free-running 64-bit fetched/discarded/stall event counters
module fetch_ctrl_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_fetched,
  input  logic        inc_discarded,
  input  logic        inc_stall,
  output logic [63:0] perf_fetched,
  output logic [63:0] perf_discarded,
  output logic [63:0] perf_stall
);
  always_ff @(posedge clk)
    if (reset) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
      perf_stall     <= '0;
    end else begin
      perf_fetched   <= perf_fetched + 64'(inc_fetched);
      perf_discarded <= perf_discarded + 64'(inc_discarded);
      perf_stall     <= perf_stall + 64'(inc_stall);
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer (PC, ibus handshake, 1-entry buffer, redirect/discard); FETCH_CTRL_PERF_EN adds perf counters
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter word_t PC_RESET    = PCINIT,
  parameter int    INSTR_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  word_t       redirect_pc,
  output fetch_data_t dataF,
  output logic        validF,
`ifdef FETCH_CTRL_PERF_EN
  output logic [63:0] perf_fetched,
  output logic [63:0] perf_discarded,
  output logic [63:0] perf_stall,
`endif
  input  logic        readyD
);
  fetch_ctrl_state_t state_q;
  word_t pc_q, addr_q;
  fetch_data_t out_q;
  logic out_v;
  assign ireq.valid = state_q != FC_IDLE;
  assign ireq.addr  = addr_q;
  assign dataF      = out_q;
  assign validF     = out_v;
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= FC_IDLE;
      pc_q    <= PC_RESET;
      addr_q  <= '0;
      out_q   <= '0;
      out_v   <= 1'b0;
    end else if (redirect_valid) begin
      pc_q    <= redirect_pc;
      out_v   <= 1'b0;
      state_q <= (state_q != FC_IDLE && !iresp.data_ok) ? FC_DISCARD : FC_IDLE;
    end else begin
      if (out_v && readyD) out_v <= 1'b0;
      if (state_q == FC_IDLE) begin
        if (!out_v || readyD) begin
          addr_q  <= pc_q;
          state_q <= FC_REQ;
        end
      end else if (iresp.data_ok) begin
        state_q <= FC_IDLE;
        if (state_q == FC_REQ) begin
          out_q <= {addr_q, iresp.data};
          out_v <= 1'b1;
          pc_q  <= addr_q + word_t'(INSTR_BYTES);
        end
      end
    end
`ifdef FETCH_CTRL_PERF_EN
  logic busy_ok;
  assign busy_ok = iresp.data_ok && state_q != FC_IDLE;
  fetch_ctrl_perf u_perf (
    .clk           (clk),
    .reset         (reset),
    .inc_fetched   (busy_ok && state_q == FC_REQ && !redirect_valid),
    .inc_discarded (busy_ok && (state_q == FC_DISCARD || redirect_valid)),
    .inc_stall     (out_v && !readyD),
    .perf_fetched  (perf_fetched),
    .perf_discarded(perf_discarded),
    .perf_stall    (perf_stall)
  );
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of fetch sequencing, stall, redirect/discard, PC wrap and reset
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset;
  ibus_req_t ireq;
  ibus_resp_t iresp;
  logic redirect_valid;
  word_t redirect_pc;
  fetch_data_t dataF;
  logic validF;
  logic readyD;
  int checks = 0;
  int errors = 0;
`ifdef FETCH_CTRL_PERF_EN
  logic [63:0] perf_fetched, perf_discarded, perf_stall;
`endif
  fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .ireq          (ireq),
    .iresp         (iresp),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dataF         (dataF),
    .validF        (validF),
`ifdef FETCH_CTRL_PERF_EN
    .perf_fetched  (perf_fetched),
    .perf_discarded(perf_discarded),
    .perf_stall    (perf_stall),
`endif
    .readyD        (readyD)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk_req(input string tag, input logic [63:0] addr);
    chk({tag, ".valid"}, 64'(ireq.valid), 64'd1);
    chk({tag, ".addr"}, ireq.addr, addr);
  endtask
  task automatic chk_out(input string tag, input logic [63:0] pc, input logic [31:0] raw);
    chk({tag, ".validF"}, 64'(validF), 64'd1);
    chk({tag, ".pc"}, dataF.instr.pc, pc);
    chk({tag, ".raw"}, 64'(dataF.instr.raw_instr), 64'(raw));
  endtask
  task automatic respond(input logic [31:0] d);
    iresp.data_ok = 1'b1;
    iresp.data = d;
    tick();
    iresp.data_ok = 1'b0;
    iresp.data = '0;
  endtask
  initial begin
    reset = 1'b1;
    iresp = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    readyD = 1'b1;
    tick();
    tick();
    chk("rst.ireq_valid", 64'(ireq.valid), 64'd0);
    chk("rst.validF", 64'(validF), 64'd0);
    chk("rst.dataF_pc", dataF.instr.pc, 64'd0);
    reset = 1'b0;
    tick();
    chk_req("t1.req0", 64'h8000_0000);
    respond(32'hA0);
    chk_out("t1.out0", 64'h8000_0000, 32'hA0);
    chk("t1.idle0", 64'(ireq.valid), 64'd0);
    tick();
    chk_req("t1.req1", 64'h8000_0004);
    chk("t1.drained", 64'(validF), 64'd0);
    respond(32'hA1);
    chk_out("t1.out1", 64'h8000_0004, 32'hA1);
    tick();
    chk_req("t1.req2", 64'h8000_0008);
    respond(32'hA2);
    chk_out("t1.out2", 64'h8000_0008, 32'hA2);
    readyD = 1'b0;
    tick();
    chk("t2.noreq_a", 64'(ireq.valid), 64'd0);
    chk_out("t2.hold_a", 64'h8000_0008, 32'hA2);
    tick();
    chk("t2.noreq_b", 64'(ireq.valid), 64'd0);
    chk_out("t2.hold_b", 64'h8000_0008, 32'hA2);
    readyD = 1'b1;
    tick();
    chk_req("t2.req3", 64'h8000_000C);
    chk("t2.drained", 64'(validF), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0004;
    respond(32'hBAD0);
    redirect_valid = 1'b0;
    chk("t4.idle", 64'(ireq.valid), 64'd0);
    chk("t4.validF", 64'(validF), 64'd0);
    tick();
    chk_req("t4.req", 64'h8000_0004);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    chk_req("t3.hold_a", 64'h8000_0004);
    chk("t3.validF_a", 64'(validF), 64'd0);
    tick();
    chk_req("t3.hold_b", 64'h8000_0004);
    tick();
    chk_req("t3.hold_c", 64'h8000_0004);
    respond(32'hBAD1);
    chk("t3.idle", 64'(ireq.valid), 64'd0);
    chk("t3.validF_b", 64'(validF), 64'd0);
    tick();
    chk_req("t3.req", 64'h8000_0100);
    chk("t3.validF_c", 64'(validF), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0100;
    tick();
    redirect_pc = 64'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    chk_req("t5.hold", 64'h8000_0100);
    respond(32'hBAD2);
    tick();
    chk_req("t5.req", 64'h8000_0200);
    respond(32'hA4);
    chk_out("t5.out", 64'h8000_0200, 32'hA4);
    tick();
    chk_req("wrap.req204", 64'h8000_0204);
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    respond(32'hBAD3);
    tick();
    chk_req("wrap.reqtop", 64'hFFFF_FFFF_FFFF_FFFC);
    respond(32'hA5);
    chk_out("wrap.out", 64'hFFFF_FFFF_FFFF_FFFC, 32'hA5);
    tick();
    chk_req("wrap.req0", 64'h0);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    chk_req("t6.discard", 64'h0);
`ifdef FETCH_CTRL_PERF_EN
    chk("perf.fetched", perf_fetched, 64'd5);
    chk("perf.discarded", perf_discarded, 64'd4);
    chk("perf.stall", perf_stall, 64'd2);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6.idle", 64'(ireq.valid), 64'd0);
    chk("t6.validF", 64'(validF), 64'd0);
`ifdef FETCH_CTRL_PERF_EN
    chk("perf.clr_fetched", perf_fetched, 64'd0);
    chk("perf.clr_discarded", perf_discarded, 64'd0);
    chk("perf.clr_stall", perf_stall, 64'd0);
`endif
    tick();
    chk_req("t6.req", 64'h8000_0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
